// File: rtl/serial_frame_controller.sv
// serial_frame_controller
//   Sequencing controller in front of the serial_decode 192-bit frame shift
//   register. It synchronises the raw serial pins, turns each serial-clock
//   rising edge into a one-cycle shift strobe, validates completed frames,
//   holds a good frame until it is acknowledged, and clears the decoder after
//   every frame, on field errors and on inter-bit timeouts.
//
// Ports
//   clock, reset_n         system clock, asynchronous active-low reset
//   serial_clock_in/data   raw serial pins (asynchronous to clock)
//   decoder_reset          one-cycle synchronous clear to serial_decode
//   decoder_serial_clock   one-cycle shift strobe to serial_decode
//   decoder_serial_data    synchronised data aligned with the strobe
//   decoder_full           serial_decode holds 192 bits
//   decoder_preamble/type  frame fields from serial_decode
//   frame_valid            decoder holds a validated frame
//   frame_ack              consumer has read the frame
//   error/timeout/overrun_count  saturating event counters
module serial_frame_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] PREAMBLE       = 32'hAAAAAAAA,
  parameter int unsigned COUNT_WIDTH    = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   serial_clock_in,
  input  logic                   serial_data_in,
  output logic                   decoder_reset,
  output logic                   decoder_serial_clock,
  output logic                   decoder_serial_data,
  input  logic                   decoder_full,
  input  logic [31:0]            decoder_preamble,
  input  logic [15:0]            decoder_type_1,
  input  logic [15:0]            decoder_type_2,
  output logic                   frame_valid,
  input  logic                   frame_ack,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [COUNT_WIDTH-1:0] timeout_count,
  output logic [COUNT_WIDTH-1:0] overrun_count
);

  localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RECEIVE,
    CHECK,
    HOLD
  } state_t;

  state_t state, next_state;

  logic clk_meta, clk_sync, clk_hist;
  logic data_meta, data_sync;
  logic pin_edge;
  logic frame_pass;

  logic [TIMER_WIDTH-1:0] timer;
  logic                   overrun_seen;

  logic strobe_next;
  logic timer_clear, timer_inc;
  logic inc_error, inc_timeout, inc_overrun;

  // Clock-path flops reset high so a pin already high at reset release does
  // not look like a rising edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_hist  <= 1'b1;
      data_meta <= 1'b0;
      data_sync <= 1'b0;
    end else begin
      clk_meta  <= serial_clock_in;
      clk_sync  <= clk_meta;
      clk_hist  <= clk_sync;
      data_meta <= serial_data_in;
      data_sync <= data_meta;
    end
  end

  assign pin_edge   = clk_sync & ~clk_hist;
  assign frame_pass = (decoder_preamble == PREAMBLE) &&
                      (decoder_type_1 == decoder_type_2);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    strobe_next = 1'b0;
    timer_clear = 1'b0;
    timer_inc   = 1'b0;
    inc_error   = 1'b0;
    inc_timeout = 1'b0;
    inc_overrun = 1'b0;
    case (state)
      CLEAR: begin
        next_state = IDLE;
      end
      IDLE: begin
        if (pin_edge) begin
          strobe_next = 1'b1;
          timer_clear = 1'b1;
          next_state  = RECEIVE;
        end
      end
      RECEIVE: begin
        strobe_next = pin_edge;
        timer_clear = pin_edge;
        timer_inc   = ~pin_edge;
        // A completed frame wins over a timeout landing in the same cycle.
        if (decoder_full) begin
          next_state = CHECK;
        end else if (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          inc_timeout = 1'b1;
          next_state  = CLEAR;
        end
      end
      CHECK: begin
        if (frame_pass) begin
          next_state = HOLD;
        end else begin
          inc_error  = 1'b1;
          next_state = CLEAR;
        end
      end
      HOLD: begin
        inc_overrun = pin_edge & ~overrun_seen;
        if (frame_ack) begin
          next_state = CLEAR;
        end
      end
      default: begin
        next_state = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      decoder_serial_clock <= 1'b0;
      decoder_serial_data  <= 1'b0;
      timer                <= '0;
      overrun_seen         <= 1'b0;
    end else begin
      decoder_serial_clock <= strobe_next;
      decoder_serial_data  <= data_sync;
      if (timer_clear) begin
        timer <= '0;
      end else if (timer_inc) begin
        timer <= timer + TIMER_WIDTH'(1);
      end
      // Re-armed in CHECK so each HOLD period counts at most one overrun.
      if (state == CHECK) begin
        overrun_seen <= 1'b0;
      end else if (inc_overrun) begin
        overrun_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error_count   <= '0;
      timeout_count <= '0;
      overrun_count <= '0;
    end else begin
      if (inc_error && (error_count != '1)) begin
        error_count <= error_count + COUNT_WIDTH'(1);
      end
      if (inc_timeout && (timeout_count != '1)) begin
        timeout_count <= timeout_count + COUNT_WIDTH'(1);
      end
      if (inc_overrun && (overrun_count != '1)) begin
        overrun_count <= overrun_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign decoder_reset = (state == CLEAR);
  assign frame_valid   = (state == HOLD);

endmodule

// File: doc/serial_frame_controller.md
# serial_frame_controller

Sequencing controller in front of `serial_decode`, the 192-bit BEP frame shift register. It synchronises the raw serial clock/data pins and converts each serial-clock rising edge into a one-cycle shift strobe for the decoder. It validates each completed frame's preamble and type fields, then holds a valid frame for the consumer until acknowledged. It clears the decoder after every frame, on errors and on inter-bit timeouts.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 4096: idle `clock` cycles without a strobe, mid-frame, before the partial frame is abandoned.
- `PREAMBLE`, 32'hAAAAAAAA: required value of `decoder_preamble`.
- `COUNT_WIDTH`, 8: width of the saturating event counters.

Ports:
- `clock` in 1: single system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `serial_clock_in` in 1: raw serial clock pin, asynchronous to `clock`.
- `serial_data_in` in 1: raw serial data pin, asynchronous to `clock`.
- `decoder_reset` out 1: synchronous active-high clear for `serial_decode`.
- `decoder_serial_clock` out 1: one-cycle shift strobe to `serial_decode`.
- `decoder_serial_data` out 1: synchronised data, aligned with the strobe.
- `decoder_full` in 1: `serial_decode` has captured 192 bits.
- `decoder_preamble` in 32: frame preamble field.
- `decoder_type_1` in 16: first type field.
- `decoder_type_2` in 16: second type field.
- `frame_valid` out 1: decoder contents are a validated frame.
- `frame_ack` in 1: consumer has read the frame.
- `error_count` out COUNT_WIDTH: frames rejected by the field check.
- `timeout_count` out COUNT_WIDTH: partial frames abandoned on timeout.
- `overrun_count` out COUNT_WIDTH: HOLD periods during which serial edges were lost.

## Operation
- **Synchroniser:** two flops on each pin, plus a history flop on the clock path.
- **Edge detect:** `edge = sync_clk & ~hist_clk`.
- **Reset values of sync/history flops:**
  - Clock-path flops reset to 1, so a pin that is high at reset release yields no edge.
  - Data-path flops reset to 0.
- **Strobe and data outputs:** `decoder_serial_clock` and `decoder_serial_data` are registered. The strobe is `edge` gated by state (IDLE or RECEIVE only). Data is the synchronised data delayed to align with the strobe.
- **States:**
  - CLEAR:
    - `decoder_reset`=1 for exactly one cycle, then go to IDLE.
    - Edges arriving in CLEAR are dropped.
  - IDLE:
    - Wait for an edge.
    - On an edge, pass the strobe through, clear the timer and go to RECEIVE.
  - RECEIVE:
    - Pass strobes through. The timer clears on each strobe and increments otherwise.
    - If `decoder_full`=1, go to CHECK. This takes priority over timeout in the same cycle.
    - Else, if the timer reaches TIMEOUT_CYCLES−1, increment `timeout_count` and go to CLEAR.
  - CHECK (one cycle):
    - Pass condition: `decoder_preamble`==PREAMBLE and `decoder_type_1`==`decoder_type_2`.
    - On pass, go to HOLD.
    - On fail, increment `error_count` and go to CLEAR.
  - HOLD:
    - `frame_valid`=1. The decoder stays full, so the consumer reads the field outputs of `serial_decode` directly.
    - Strobes are suppressed.
    - On the first edge seen in this HOLD, increment `overrun_count` once. Further edges in the same HOLD are not counted.
    - On `frame_ack`=1, go to CLEAR.
- **Counters:**
  - Saturate at 2^COUNT_WIDTH−1; they never wrap.
  - Cleared only by `reset_n`.
- **Timer width:** clog2(TIMEOUT_CYCLES)+1 bits.

## Timing
- **Reset values:**
  - State CLEAR, `decoder_reset`=1.
  - `decoder_serial_clock`=0, `decoder_serial_data`=0, `frame_valid`=0, all counters 0.
- **After `reset_n` deasserts:** one CLEAR cycle, then IDLE.
- **Strobe latency:** a pin rising edge produces `decoder_serial_clock`=1 for exactly one cycle, 3 or 4 `clock` cycles later (synchroniser uncertainty). There is one strobe per pin edge, however long the pin stays high.
- **Frame completion:** `decoder_full` rises the cycle after the 192nd strobe. CHECK occupies the next cycle, and `frame_valid` asserts the cycle after CHECK.
- **Acknowledge:** `frame_valid` is registered and deasserts the cycle after `frame_ack` is sampled high. `decoder_reset` pulses in that same cycle, and IDLE follows.
- **`frame_ack` outside HOLD:** ignored.
- **Pin clock rate:** must be ≤ `clock`/4. Faster edges are undefined.
- **Mid-operation reset:** asserting `reset_n` in any state immediately forces the reset values. Any partial or held frame is discarded.

## Test plan
- **Good frame:** 192 serial edges carrying the sample BEP frame (preamble AAAAAAAA, type D391/D391). Required: `frame_valid`=1 two cycles after `decoder_full`; after `frame_ack`, one `decoder_reset` pulse, return to IDLE, all counters 0.
- **Bad preamble:** same frame with preamble bit 0 flipped. Required: `error_count`=1, `frame_valid` never asserts, one `decoder_reset` pulse.
- **Timeout:** 50 edges, then a silence of TIMEOUT_CYCLES. Required: `timeout_count`=1, decoder cleared. A following good frame then decodes correctly.
- **Overrun:** a good frame, then 10 more edges before `frame_ack`. Required: `overrun_count`=1 and decoder contents unchanged. Also drive 300 good frames with a bad type; `error_count` must saturate at 255.
- **Reset and slow edges:** hold `serial_clock_in` high through reset release. Required: no strobe. Assert `reset_n` mid-RECEIVE: all outputs return to reset values. A pin edge held high for 20 cycles gives exactly one strobe.
